// File: rtl/systolic_matmul_acc.sv
// Output-stationary N x N systolic matrix multiplier with cross-tile accumulation.
// Results are rounded half-up and saturated to signed Q(W-FRAC).FRAC on emission.
module systolic_matmul_acc #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int FRAC  = 4,
  parameter int ACC_W = 24
) (
  input  logic                         i_clk,
  input  logic                         i_arst_n,
  input  logic [N-1:0][N-1:0][W-1:0]   i_a,
  input  logic [N-1:0][N-1:0][W-1:0]   i_b,
  input  logic                         i_valid,
  input  logic                         i_accumulate,
  input  logic                         i_last,
  output logic                         o_ready,
  output logic [N-1:0][N-1:0][W-1:0]   o_c,
  output logic                         o_sat,
  output logic                         o_valid,
  input  logic                         i_ready
);

  localparam int CW       = $clog2(3 * N);
  localparam int LAST_CNT = 3 * N - 1;
  localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1 << (FRAC - 1));
  localparam logic signed [ACC_W:0] MAXV = (ACC_W + 1)'((1 << (W - 1)) - 1);
  localparam logic signed [ACC_W:0] MINV = (ACC_W + 1)'(-(1 << (W - 1)));

  typedef enum logic [1:0] {IDLE, FEED, OUT} state_t;

  state_t state, state_nx;

  logic [CW-1:0]                cnt;
  logic                         last_q;
  logic [N-1:0][N-1:0][W-1:0]   a_q;
  logic [N-1:0][N-1:0][W-1:0]   b_q;
  logic signed [W-1:0]          a_pipe [N][N];
  logic signed [W-1:0]          b_pipe [N][N];
  logic signed [W-1:0]          a_in   [N][N];
  logic signed [W-1:0]          b_in   [N][N];
  logic signed [2*W-1:0]        prod   [N][N];
  logic signed [ACC_W-1:0]      acc    [N][N];
  logic signed [ACC_W:0]        rnd    [N][N];
  logic signed [ACC_W:0]        shv    [N][N];
  logic [N*N-1:0]               sat_vec;
  logic [N-1:0][N-1:0][W-1:0]   c_nx;
  logic                         accept;
  logic                         feed_done;

  assign accept    = i_valid && o_ready;
  assign feed_done = (state == FEED) && (cnt == CW'(LAST_CNT));

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nx = FEED;
      end
      FEED: begin
        if (feed_done) state_nx = last_q ? OUT : IDLE;
      end
      OUT: begin
        o_valid = 1'b1;
        if (i_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Edge inputs: element k of row/column x enters at cycle x+k, zero otherwise.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        a_in[i][j] = '0;
        b_in[i][j] = '0;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (cnt == CW'(i + k)) begin
          a_in[i][0] = a_q[i][k];
          b_in[0][i] = b_q[k][i];
        end
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 1; j < N; j++) begin
        a_in[i][j] = a_pipe[i][j-1];
        b_in[j][i] = b_pipe[j-1][i];
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        prod[i][j] = (2 * W)'(a_in[i][j]) * (2 * W)'(b_in[i][j]);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      last_q <= 1'b0;
      cnt    <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
          acc[i][j]    <= '0;
        end
      end
    end else if (accept) begin
      a_q    <= i_a;
      b_q    <= i_b;
      last_q <= i_last;
      cnt    <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
          if (!i_accumulate) acc[i][j] <= '0;
        end
      end
    end else if (state == FEED) begin
      cnt <= cnt + CW'(1);
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          a_pipe[i][j] <= a_in[i][j];
          b_pipe[i][j] <= b_in[i][j];
          acc[i][j]    <= acc[i][j] + ACC_W'(prod[i][j]);
        end
      end
    end
  end

  // Rounding is done one bit wider so the half-LSB add cannot wrap.
  always_comb begin
    sat_vec = '0;
    c_nx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        rnd[i][j] = (ACC_W + 1)'(acc[i][j]) + HALF;
        shv[i][j] = rnd[i][j] >>> FRAC;
        if (shv[i][j] > MAXV) begin
          c_nx[i][j]       = MAXV[W-1:0];
          sat_vec[i*N + j] = 1'b1;
        end else if (shv[i][j] < MINV) begin
          c_nx[i][j]       = MINV[W-1:0];
          sat_vec[i*N + j] = 1'b1;
        end else begin
          c_nx[i][j] = shv[i][j][W-1:0];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_c   <= '0;
      o_sat <= 1'b0;
    end else if (feed_done && last_q) begin
      o_c   <= c_nx;
      o_sat <= |sat_vec;
    end
  end

endmodule

// File: tb/tb_systolic_matmul_acc.sv
// Self-checking bench for systolic_matmul_acc: directed vector table, corner
// sequences and randomized tiles against a plain-arithmetic matrix model.
module tb_systolic_matmul_acc;

  localparam int N = 4, W = 8, FRAC = 4, ACC_W = 24;
  localparam int CB = N * N * W;
  localparam int LAT = 3 * N;

  typedef logic [N-1:0][N-1:0][W-1:0] tile_t;
  typedef logic [N-1:0][W-1:0] row_t;

  typedef struct {
    tile_t      a;
    tile_t      b;
    logic [7:0] exp00;
    logic [7:0] exp01;
    logic       exp_sat;
  } vec_t;

  logic  clk = 1'b0, rst_n = 1'b0;
  tile_t a = '0, b = '0, c;
  logic  valid = 1'b0, accm = 1'b0, lst = 1'b0, iready = 1'b1;
  logic  ready, sat, ovalid;

  int cyc = 0;
  int checks = 0, errors = 0;
  longint macc [N][N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_matmul_acc #(.N(N), .W(W), .FRAC(FRAC), .ACC_W(ACC_W)) dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_a(a), .i_b(b), .i_valid(valid),
    .i_accumulate(accm), .i_last(lst), .o_ready(ready), .o_c(c),
    .o_sat(sat), .o_valid(ovalid), .i_ready(iready)
  );

  task automatic chk(input string name, input logic [CB-1:0] act, input logic [CB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic row_t mk_row(input logic [7:0] e0, e1, e2, e3);
    row_t r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
    return r;
  endfunction

  function automatic tile_t fill(input logic [7:0] v);
    tile_t t;
    for (int r = 0; r < N; r++) for (int k = 0; k < N; k++) t[r][k] = v;
    return t;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int r = 0; r < N; r++) for (int k = 0; k < N; k++) t[r][k] = 8'($urandom);
    return t;
  endfunction

  // Reference: C += A*B in exact integers, wrapped to ACC_W bits.
  task automatic model_tile(input tile_t ta, input tile_t tb_, input logic tacc);
    for (int r = 0; r < N; r++)
      for (int q = 0; q < N; q++) begin
        if (!tacc) macc[r][q] = 0;
        for (int k = 0; k < N; k++)
          macc[r][q] += longint'($signed(ta[r][k])) * longint'($signed(tb_[k][q]));
        macc[r][q] = (macc[r][q] <<< (64 - ACC_W)) >>> (64 - ACC_W);
      end
  endtask

  task automatic model_out(output tile_t ec, output logic es);
    longint v, hi, lo;
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    es = 1'b0;
    for (int r = 0; r < N; r++)
      for (int q = 0; q < N; q++) begin
        v = (macc[r][q] + (longint'(1) << (FRAC - 1))) >>> FRAC;
        if (v > hi) begin v = hi; es = 1'b1; end
        else if (v < lo) begin v = lo; es = 1'b1; end
        ec[r][q] = v[W-1:0];
      end
  endtask

  task automatic do_tile(input tile_t ta, input tile_t tb_, input logic tacc, input logic tlast,
                         input logic hold, input string name, output tile_t got);
    int    t0;
    tile_t ec;
    logic  es;
    logic  seen;
    model_tile(ta, tb_, tacc);
    iready = !hold;
    for (int t = 0; t < 100 && !ready; t++) @(negedge clk);
    chk({name, "_ready_wait"}, ready, 1);
    a = ta; b = tb_; accm = tacc; lst = tlast; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    t0 = cyc;
    chk({name, "_busy"}, ready, 0);
    if (tlast) begin
      for (int t = 0; t < LAT + 20 && !ovalid; t++) @(negedge clk);
      chk({name, "_latency"}, CB'(cyc - t0), CB'(LAT));
      got = c;
      model_out(ec, es);
      chk({name, "_c"}, c, ec);
      chk({name, "_sat"}, sat, es);
      if (!hold) begin
        @(posedge clk);
        @(negedge clk);
        chk({name, "_valid_fall"}, ovalid, 0);
        chk({name, "_ready_rise"}, ready, 1);
      end
    end else begin
      seen = 1'b0;
      for (int t = 0; t < LAT + 20 && !ready; t++) begin
        if (ovalid) seen = 1'b1;
        @(negedge clk);
      end
      chk({name, "_ready_return"}, CB'(cyc - t0), CB'(LAT));
      chk({name, "_no_valid"}, seen | ovalid, 0);
      got = c;
    end
  endtask

  vec_t  vecs [5];
  tile_t got, held, ident, bb, exp_t;
  int    vcount;

  initial begin
    vecs[0].a[0] = mk_row(8'h08, 8'hF8, 8'h0C, 8'h10);
    vecs[0].a[1] = mk_row(8'h10, 8'h0C, 8'hF0, 8'h14);
    vecs[0].a[2] = mk_row(8'h0C, 8'h10, 8'h14, 8'hEC);
    vecs[0].a[3] = mk_row(8'h10, 8'h18, 8'h08, 8'h0C);
    vecs[0].b[0] = mk_row(8'h14, 8'hF0, 8'h0C, 8'h10);
    vecs[0].b[1] = mk_row(8'h10, 8'h0C, 8'h08, 8'hF4);
    vecs[0].b[2] = mk_row(8'h0C, 8'h10, 8'h08, 8'h14);
    vecs[0].b[3] = mk_row(8'h08, 8'h04, 8'h14, 8'h10);
    vecs[0].exp00 = 8'h13; vecs[0].exp01 = 8'h02; vecs[0].exp_sat = 1'b0;
    vecs[1].a = '0; vecs[1].b = '0; vecs[1].a[0][0] = 8'h01; vecs[1].b[0][0] = 8'h08;
    vecs[1].exp00 = 8'h01; vecs[1].exp01 = 8'h00; vecs[1].exp_sat = 1'b0;
    vecs[2].a = '0; vecs[2].b = '0; vecs[2].a[0][0] = 8'hFF; vecs[2].b[0][0] = 8'h08;
    vecs[2].exp00 = 8'h00; vecs[2].exp01 = 8'h00; vecs[2].exp_sat = 1'b0;
    vecs[3].a = fill(8'h70); vecs[3].b = fill(8'h70);
    vecs[3].exp00 = 8'h7F; vecs[3].exp01 = 8'h7F; vecs[3].exp_sat = 1'b1;
    vecs[4].a = fill(8'h70); vecs[4].b = fill(8'h90);
    vecs[4].exp00 = 8'h80; vecs[4].exp01 = 8'h80; vecs[4].exp_sat = 1'b1;

    for (int r = 0; r < N; r++) for (int q = 0; q < N; q++) macc[r][q] = 0;

    // Reset and idle
    @(negedge clk);
    chk("rst_valid", ovalid, 0);
    chk("rst_c", c, 0);
    chk("rst_sat", sat, 0);
    chk("rst_ready", ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", ready, 1);
    vcount = 0;
    for (int t = 0; t < 50; t++) begin
      if (ovalid) vcount++;
      @(negedge clk);
    end
    chk("idle_no_valid", CB'(vcount), 0);

    // Directed vector table
    for (int v = 0; v < 5; v++) begin
      do_tile(vecs[v].a, vecs[v].b, 1'b0, 1'b1, 1'b0, "vec", got);
      chk("vec_c00", got[0][0], vecs[v].exp00);
      chk("vec_c01", got[0][1], vecs[v].exp01);
      chk("vec_sat_tbl", sat, vecs[v].exp_sat);
    end

    // Accumulation with identity A (1.0 on the diagonal)
    ident = '0;
    for (int r = 0; r < N; r++) ident[r][r] = 8'h10;
    bb = rand_tile();
    do_tile(ident, bb, 1'b0, 1'b0, 1'b0, "acc1", got);
    do_tile(ident, bb, 1'b1, 1'b1, 1'b0, "acc2", got);
    for (int r = 0; r < N; r++)
      for (int q = 0; q < N; q++) begin
        int v2;
        v2 = 2 * int'($signed(bb[r][q]));
        if (v2 > 127) v2 = 127;
        if (v2 < -128) v2 = -128;
        exp_t[r][q] = 8'(v2);
      end
    chk("acc2_sat2b", got, exp_t);
    do_tile(ident, bb, 1'b0, 1'b1, 1'b0, "acc3", got);
    chk("acc3_b_only", got, bb);

    // Backpressure with ignored i_valid pulses
    do_tile(rand_tile(), rand_tile(), 1'b0, 1'b1, 1'b1, "bp", held);
    for (int t = 0; t < 5; t++) begin
      a = rand_tile(); accm = 1'b0; lst = 1'b1; valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_c_stable", c, held);
      chk("bp_valid_hold", ovalid, 1);
      chk("bp_ready_low", ready, 0);
    end
    valid = 1'b0;
    iready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_valid_fall", ovalid, 0);
    chk("bp_ready_rise", ready, 1);
    do_tile(rand_tile(), rand_tile(), 1'b0, 1'b1, 1'b0, "bp_next", got);

    // Reset mid-FEED discards partial accumulation
    a = rand_tile(); b = rand_tile(); accm = 1'b0; lst = 1'b1; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", ready, 1);
    chk("midrst_valid", ovalid, 0);
    chk("midrst_c", c, 0);
    chk("midrst_sat", sat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < N; r++) for (int q = 0; q < N; q++) macc[r][q] = 0;
    do_tile(rand_tile(), rand_tile(), 1'b1, 1'b1, 1'b0, "midrst_new", got);

    // Randomized tile sequences
    for (int t = 0; t < 12; t++) begin
      logic ra, rl;
      ra = 1'($urandom_range(0, 1));
      rl = (t == 11) ? 1'b1 : 1'($urandom_range(0, 1));
      do_tile(rand_tile(), rand_tile(), ra, rl, 1'b0, "rand", got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_matmul_acc.md
# systolic_matmul_acc

Parametrised N×N output-stationary systolic matrix multiplier for signed fixed-point (Qm.f) operands. It accepts one A/B tile pair per ready/valid handshake and accumulates partial products across successive tiles, so K-dimension tiling works when K > N. When a tile marked last finishes, it emits a rounded, saturated N×N result under output backpressure. It is the next-generation replacement for the fixed 4×4 Q4.4 array in the ECG classifier's dense-layer datapath.

## Interface
- N, 4, array dimension (rows = columns = tile depth); N ≥ 2
- W, 8, operand and result width, signed two's complement
- FRAC, 4, fractional bits of operands and result; 1 ≤ FRAC < W
- ACC_W, 24, per-PE accumulator width, signed; ACC_W ≥ 2W + clog2(N)

- i_clk  in  1  clock, rising edge
- i_arst_n  in  1  asynchronous active-low reset
- i_a  in  [N-1:0][N-1:0][W-1:0]  A tile, i_a[row][k]
- i_b  in  [N-1:0][N-1:0][W-1:0]  B tile, i_b[k][col]
- i_valid  in  1  tile offered
- i_accumulate  in  1  sampled at accept: 1 = add into existing accumulators, 0 = clear them first
- i_last  in  1  sampled at accept: 1 = emit the result after this tile
- o_ready  out  1  block can accept a tile
- o_c  out  [N-1:0][N-1:0][W-1:0]  result, o_c[row][col], Q(W-FRAC).FRAC
- o_sat  out  1  at least one element of o_c was saturated
- o_valid  out  1  o_c / o_sat valid
- i_ready  in  1  downstream accepts the result

## Operation
- FSM states: IDLE, FEED, OUT.
- IDLE: o_ready=1. On accept (i_valid && o_ready):
  - register i_a, i_b, i_accumulate and i_last;
  - if i_accumulate=0, clear all accumulators;
  - go to FEED.
- FEED: o_ready=0. Feed A rows from the left and B columns from the top with a row/column skew of one cycle per index, padding with zeros.
  - Each PE(i,j) computes acc += a·b, passes a right and b down.
  - The FEED counter runs 3N-1 cycles.
  - Exit to OUT if last=1; otherwise to IDLE, keeping the accumulators.
- OUT: o_c and o_sat are registered on entry. o_valid=1, o_ready=0. o_c and o_sat hold stable until i_ready=1. Then go to IDLE.
- Arithmetic:
  - product is signed W×W → 2W bits with 2·FRAC fraction bits, sign-extended to ACC_W;
  - the accumulator wraps modulo 2^ACC_W;
  - output = (acc + 2^(FRAC-1)) >>> FRAC (round half up, arithmetic shift);
  - then saturate to [-2^(W-1), 2^(W-1)-1];
  - o_sat = OR over all elements of their saturation flags.
- i_valid while o_ready=0 is ignored; no accept is registered.
- i_accumulate=1 on the first tile after reset adds to zero.

## Timing
- Reset (async assert, sync release): state IDLE, o_ready=1, o_valid=0, o_c=0, o_sat=0, accumulators and skew registers = 0.
- Accept on edge E0.
  - o_ready is low from the cycle after E0.
  - If last=1, o_valid rises at E0+3N (N=4 → 12 cycles).
  - If last=0, o_ready returns high at E0+3N and o_valid stays 0.
- Result handshake completes on the edge with o_valid && i_ready. o_valid falls and o_ready rises at that edge. A new accept is possible on the next edge at the earliest; there is no same-cycle turnaround.
- Reset asserted mid-FEED or mid-OUT aborts immediately: outputs return to reset values, and partial accumulation is discarded.
- Minimum tile throughput: one tile per 3N+1 cycles (non-last tiles).

## Test plan
- Reset then idle: outputs match reset values; o_ready=1 one cycle after deassert; no o_valid for 50 cycles.
- N=4, W=8, FRAC=4 single last tile:
  - A rows {08,F8,0C,10},{10,0C,F0,14},{0C,10,14,EC},{10,18,08,0C};
  - B rows {14,F0,0C,10},{10,0C,08,F4},{0C,10,08,14},{08,04,14,10};
  - → o_c[0][0]=13, o_c[0][1]=02, full matrix equals the golden model, o_sat=0, o_valid exactly 12 cycles after accept.
- Rounding and saturation:
  - A[0][0]=01, B[0][0]=08 → c[0][0]=01;
  - A[0][0]=FF, B[0][0]=08 → c[0][0]=00;
  - all A=B=70 → all c=7F, o_sat=1;
  - all A=70, B=90 → all c=80, o_sat=1.
- Accumulation: A=identity (10 on diagonal), arbitrary B.
  - Tile 1: accumulate=0, last=0 → no o_valid, o_ready high again at E0+12.
  - Tile 2: accumulate=1, last=1 → o_c = saturate(2·B).
  - A third tile with accumulate=0 and last=1 yields B only.
- Backpressure: hold i_ready=0 for 5 cycles during OUT.
  - o_c and o_valid are stable and o_ready=0; i_valid pulses are ignored.
  - On the i_ready=1 edge, o_valid falls; the next tile is accepted one cycle later.
- Reset mid-FEED (cycle 5 after accept), then a fresh last tile with accumulate=1 → result equals A·B of the new tile only.
